// File: rtl/rx_link_ctrl_pkg.sv
// Shared encodings and widths for the 8b/10b receive-link bring-up controller.
package rx_link_ctrl_pkg;

    localparam int TIMER_W = 16;
    localparam int CNT_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET_RX  = 3'd1,
        ST_WAIT_SYNC = 3'd2,
        ST_CHECK     = 3'd3,
        ST_RUN       = 3'd4,
        ST_BACKOFF   = 3'd5,
        ST_FAIL      = 3'd6,
        ST_UNUSED    = 3'd7
    } link_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rx_link_ctrl_err_window.sv
// Windowed decoder-error counter; reports window end and threshold hit including the current error.
module rx_err_window
    import rx_link_ctrl_pkg::*;
#(
    parameter int ERR_THR = 4
) (
    input  logic               WCLK,
    input  logic               RESET,
    input  logic               clr,
    input  logic               count_en,
    input  logic               roll_en,
    input  logic               err,
    input  logic [TIMER_W-1:0] timer,
    input  logic [TIMER_W-1:0] last_idx,
    output logic               win_end,
    output logic               thr_hit
);

    logic [CNT_W-1:0] win_cnt;
    logic [CNT_W:0]   sum;

    assign sum     = {1'b0, win_cnt} + {{CNT_W{1'b0}}, err};
    assign win_end = (timer == last_idx);
    assign thr_hit = count_en && (sum >= (CNT_W+1)'(ERR_THR));

    // The window count clears after the last cycle has been evaluated.
    always_ff @(posedge WCLK) begin
        if (RESET || clr || (roll_en && win_end)) begin
            win_cnt <= '0;
        end else if (count_en && err && (win_cnt != '1)) begin
            win_cnt <= win_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rx_link_ctrl.sv
// Receive-link bring-up and supervision: reset pulse, lock wait, qualification, run, backoff and retry.
module rx_link_ctrl
    import rx_link_ctrl_pkg::*;
#(
    parameter int RST_LEN      = 16,
    parameter int SYNC_TIMEOUT = 4096,
    parameter int CHECK_LEN    = 1024,
    parameter int WIN_LEN      = 1024,
    parameter int ERR_THR      = 4,
    parameter int BACKOFF_LEN  = 256,
    parameter int MAX_RETRY    = 8
) (
    input  logic             WCLK,
    input  logic             RESET,
    input  logic             enable_req,
    input  logic             err_reset,
    input  logic             rec_sync_ready,
    input  logic             decoder_err,
    output logic             rx_reset,
    output logic             enable_rx,
    output logic             link_up,
    output logic             fail,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retry_cnt,
    output logic [CNT_W-1:0] link_err_cnt
);

    localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(RST_LEN - 1);
    localparam logic [TIMER_W-1:0] SYNC_LAST    = TIMER_W'(SYNC_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] CHECK_LAST   = TIMER_W'(CHECK_LEN - 1);
    localparam logic [TIMER_W-1:0] WIN_LAST     = TIMER_W'(WIN_LEN - 1);
    localparam logic [TIMER_W-1:0] BACKOFF_LAST = TIMER_W'(BACKOFF_LEN - 1);
    localparam logic [CNT_W-1:0]   RETRY_LIM    = CNT_W'(MAX_RETRY);

    link_state_t        state_q;
    link_state_t        state_nxt;
    logic [TIMER_W-1:0] timer_q;
    logic [CNT_W-1:0]   retry_q;
    logic [CNT_W-1:0]   lerr_q;
    logic               err_q;
    logic               state_chg;
    logic               in_run;
    logic               counting;
    logic               win_end;
    logic               thr_hit;

    assign err_q     = decoder_err & rec_sync_ready;
    assign state_chg = (state_nxt != state_q);
    assign in_run    = (state_q == ST_RUN);
    assign counting  = (state_q == ST_CHECK) || in_run;

    rx_err_window #(
        .ERR_THR (ERR_THR)
    ) u_err_window (
        .WCLK     (WCLK),
        .RESET    (RESET),
        .clr      (state_chg),
        .count_en (counting),
        .roll_en  (in_run),
        .err      (err_q),
        .timer    (timer_q),
        .last_idx (in_run ? WIN_LAST : CHECK_LAST),
        .win_end  (win_end),
        .thr_hit  (thr_hit)
    );

    always_ff @(posedge WCLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable_req) state_nxt = ST_RESET_RX;
            end
            ST_RESET_RX: begin
                if (timer_q == RST_LAST) state_nxt = ST_WAIT_SYNC;
            end
            ST_WAIT_SYNC: begin
                if (rec_sync_ready)              state_nxt = ST_CHECK;
                else if (timer_q == SYNC_LAST)   state_nxt = ST_BACKOFF;
            end
            ST_CHECK: begin
                if (!rec_sync_ready || thr_hit)  state_nxt = ST_BACKOFF;
                else if (win_end)                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!rec_sync_ready || thr_hit)  state_nxt = ST_BACKOFF;
            end
            ST_BACKOFF: begin
                // retry_q already holds the count incremented on entry
                if ((MAX_RETRY != 0) && (retry_q >= RETRY_LIM)) state_nxt = ST_FAIL;
                else if (timer_q == BACKOFF_LAST)               state_nxt = ST_RESET_RX;
            end
            ST_FAIL: begin
                state_nxt = ST_FAIL;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (!enable_req) state_nxt = ST_IDLE;
    end

    // Shared timer restarts on every state entry and at each RUN window boundary.
    always_ff @(posedge WCLK) begin
        if (RESET) begin
            timer_q <= '0;
        end else if (state_chg || (in_run && win_end)) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + 1'b1;
        end
    end

    always_ff @(posedge WCLK) begin
        if (RESET) begin
            retry_q <= '0;
        end else if (state_chg) begin
            if ((state_q == ST_IDLE) || (state_nxt == ST_RUN)) begin
                retry_q <= '0;
            end else if (state_nxt == ST_BACKOFF) begin
                retry_q <= sat_inc(retry_q);
            end
        end
    end

    always_ff @(posedge WCLK) begin
        if (RESET) begin
            lerr_q <= '0;
        end else if (err_reset) begin
            lerr_q <= '0;
        end else if (err_q && counting) begin
            lerr_q <= sat_inc(lerr_q);
        end
    end

    always_ff @(posedge WCLK) begin
        if (RESET) begin
            rx_reset  <= 1'b0;
            enable_rx <= 1'b0;
            link_up   <= 1'b0;
            fail      <= 1'b0;
        end else begin
            rx_reset  <= (state_q == ST_RESET_RX);
            enable_rx <= in_run;
            link_up   <= in_run;
            fail      <= (state_q == ST_FAIL);
        end
    end

    assign state        = state_q;
    assign retry_cnt    = retry_q;
    assign link_err_cnt = lerr_q;

endmodule

// File: tb/tb_rx_link_ctrl.sv
// Self-checking bench for rx_link_ctrl: hand vectors, corner sequences and a randomized run against a reference model.
module tb_rx_link_ctrl;

    localparam int RST_LEN      = 4;
    localparam int SYNC_TIMEOUT = 32;
    localparam int CHECK_LEN    = 16;
    localparam int WIN_LEN      = 16;
    localparam int ERR_THR      = 2;
    localparam int BACKOFF_LEN  = 8;
    localparam int MAX_RETRY    = 3;

    logic       WCLK = 1'b0;
    logic       RESET;
    logic       enable_req;
    logic       err_reset;
    logic       rec_sync_ready;
    logic       decoder_err;
    logic       rx_reset;
    logic       enable_rx;
    logic       link_up;
    logic       fail;
    logic [2:0] state;
    logic [7:0] retry_cnt;
    logic [7:0] link_err_cnt;

    int checks = 0;
    int errors = 0;

    always #5 WCLK = ~WCLK;

    rx_link_ctrl #(
        .RST_LEN      (RST_LEN),
        .SYNC_TIMEOUT (SYNC_TIMEOUT),
        .CHECK_LEN    (CHECK_LEN),
        .WIN_LEN      (WIN_LEN),
        .ERR_THR      (ERR_THR),
        .BACKOFF_LEN  (BACKOFF_LEN),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .WCLK           (WCLK),
        .RESET          (RESET),
        .enable_req     (enable_req),
        .err_reset      (err_reset),
        .rec_sync_ready (rec_sync_ready),
        .decoder_err    (decoder_err),
        .rx_reset       (rx_reset),
        .enable_rx      (enable_rx),
        .link_up        (link_up),
        .fail           (fail),
        .state          (state),
        .retry_cnt      (retry_cnt),
        .link_err_cnt   (link_err_cnt)
    );

    // Reference model: phase, cycles spent in phase, errors in current window, counters.
    int m_st, m_age, m_werr, m_retry, m_lerr;
    bit m_rxr, m_en, m_fail;

    task automatic model_step();
        int  nst;
        bit  errq;
        if (RESET) begin
            m_st = 0; m_age = 0; m_werr = 0; m_retry = 0; m_lerr = 0;
            m_rxr = 0; m_en = 0; m_fail = 0;
            return;
        end
        errq   = decoder_err && rec_sync_ready;
        m_rxr  = (m_st == 1);
        m_en   = (m_st == 4);
        m_fail = (m_st == 6);
        if (err_reset) m_lerr = 0;
        else if (errq && (m_st == 3 || m_st == 4)) m_lerr = (m_lerr < 255) ? m_lerr + 1 : 255;
        nst = m_st;
        case (m_st)
            0: nst = 1;
            1: if (m_age == RST_LEN - 1) nst = 2;
            2: if (rec_sync_ready) nst = 3; else if (m_age == SYNC_TIMEOUT - 1) nst = 5;
            3: if (!rec_sync_ready || (m_werr + errq >= ERR_THR)) nst = 5;
               else if (m_age == CHECK_LEN - 1) nst = 4;
            4: if (!rec_sync_ready || (m_werr + errq >= ERR_THR)) nst = 5;
            5: if (MAX_RETRY != 0 && m_retry >= MAX_RETRY) nst = 6;
               else if (m_age == BACKOFF_LEN - 1) nst = 1;
            6: nst = 6;
            default: nst = 0;
        endcase
        if (!enable_req) nst = 0;
        if (nst != m_st) begin
            if (m_st == 0 || nst == 4) m_retry = 0;
            if (nst == 5) m_retry = (m_retry < 255) ? m_retry + 1 : 255;
            m_st = nst; m_age = 0; m_werr = 0;
        end else begin
            if (m_st == 3 || m_st == 4) m_werr += errq;
            if (m_st == 4 && (m_age % WIN_LEN) == WIN_LEN - 1) m_werr = 0;
            m_age++;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        logic [31:0] act;
        logic [31:0] exp;
        @(posedge WCLK);
        #1;
        model_step();
        act = {9'd0, state, rx_reset, enable_rx, link_up, fail, retry_cnt, link_err_cnt};
        exp = {9'd0, m_st[2:0], m_rxr, m_en, m_en, m_fail, m_retry[7:0], m_lerr[7:0]};
        check("model", act, exp);
    endtask

    task automatic wait_state(input logic [2:0] tgt, input int limit, input string name);
        int n = 0;
        while (state !== tgt && n < limit) begin
            tick();
            n++;
        end
        check(name, {29'd0, state}, {29'd0, tgt});
    endtask

    task automatic bring_up();
        enable_req = 1; rec_sync_ready = 1; decoder_err = 0; err_reset = 0;
        wait_state(3'd4, 100, "bring_up");
    endtask

    typedef struct {
        int         n;
        bit         sync;
        bit         derr;
        logic [2:0] st;
        bit         rxr;
        bit         enr;
        bit         fl;
        logic [7:0] retry;
        logic [7:0] lerr;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int cyc;
        logic [7:0] lerr_before;

        // Clean bring-up, then RUN windows and an error burst, from a fresh reset.
        vecs[0]  = '{1,  0, 0, 3'd1, 0, 0, 0, 8'd0, 8'd0};
        vecs[1]  = '{1,  0, 0, 3'd1, 1, 0, 0, 8'd0, 8'd0};
        vecs[2]  = '{3,  0, 0, 3'd2, 1, 0, 0, 8'd0, 8'd0};
        vecs[3]  = '{1,  0, 0, 3'd2, 0, 0, 0, 8'd0, 8'd0};
        vecs[4]  = '{9,  0, 0, 3'd2, 0, 0, 0, 8'd0, 8'd0};
        vecs[5]  = '{1,  1, 0, 3'd3, 0, 0, 0, 8'd0, 8'd0};
        vecs[6]  = '{15, 1, 0, 3'd3, 0, 0, 0, 8'd0, 8'd0};
        vecs[7]  = '{1,  1, 0, 3'd4, 0, 0, 0, 8'd0, 8'd0};
        vecs[8]  = '{1,  1, 0, 3'd4, 0, 1, 0, 8'd0, 8'd0};
        vecs[9]  = '{1,  1, 1, 3'd4, 0, 1, 0, 8'd0, 8'd1};
        vecs[10] = '{14, 1, 0, 3'd4, 0, 1, 0, 8'd0, 8'd1};
        vecs[11] = '{1,  1, 1, 3'd4, 0, 1, 0, 8'd0, 8'd2};
        vecs[12] = '{1,  1, 1, 3'd5, 0, 1, 0, 8'd1, 8'd3};
        vecs[13] = '{1,  1, 0, 3'd5, 0, 0, 0, 8'd1, 8'd3};
        vecs[14] = '{6,  1, 0, 3'd5, 0, 0, 0, 8'd1, 8'd3};
        vecs[15] = '{1,  1, 0, 3'd1, 0, 0, 0, 8'd1, 8'd3};

        RESET = 1; enable_req = 0; err_reset = 0; rec_sync_ready = 0; decoder_err = 0;
        tick(); tick();
        check("reset_vals", {9'd0, state, rx_reset, enable_rx, link_up, fail, retry_cnt, link_err_cnt}, 32'd0);
        RESET = 0;

        enable_req = 1;
        foreach (vecs[i]) begin
            rec_sync_ready = vecs[i].sync;
            decoder_err    = vecs[i].derr;
            for (int k = 0; k < vecs[i].n; k++) tick();
            check($sformatf("vec%0d", i),
                  {10'd0, state, rx_reset, enable_rx, fail, retry_cnt, link_err_cnt},
                  {10'd0, vecs[i].st, vecs[i].rxr, vecs[i].enr, vecs[i].fl, vecs[i].retry, vecs[i].lerr});
        end

        // No lock: three timed-out attempts end in FAIL after 127 edges.
        decoder_err = 0; enable_req = 0;
        tick();
        check("to_idle", {29'd0, state}, 32'd0);
        enable_req = 1; rec_sync_ready = 0;
        cyc = 0;
        while (fail !== 1'b1 && cyc < 400) begin
            tick();
            cyc++;
        end
        check("nolock_cycles", cyc, 127);
        check("nolock_state", {29'd0, state}, 32'd6);
        check("nolock_retry", {24'd0, retry_cnt}, 32'd3);
        enable_req = 0;
        tick();
        check("fail_exit_state", {29'd0, state}, 32'd0);
        tick();
        check("fail_exit_flag", {31'd0, fail}, 32'd0);

        // Lock loss in RUN; an error without lock is not counted.
        bring_up();
        lerr_before = link_err_cnt;
        rec_sync_ready = 0; decoder_err = 1;
        tick();
        check("lockloss_state", {29'd0, state}, 32'd5);
        check("lockloss_noerr", {24'd0, link_err_cnt}, {24'd0, lerr_before});
        decoder_err = 0;

        // enable_req drop during CHECK.
        enable_req = 0;
        tick();
        enable_req = 1; rec_sync_ready = 1;
        wait_state(3'd3, 40, "reach_check");
        enable_req = 0;
        tick();
        check("drop_in_check", {29'd0, state}, 32'd0);

        // err_reset beats a simultaneous qualified error.
        bring_up();
        decoder_err = 1; err_reset = 1;
        tick();
        check("errreset_prio", {24'd0, link_err_cnt}, 32'd0);
        decoder_err = 0; err_reset = 0;

        // One error per 16-cycle window keeps RUN while the counter saturates.
        for (int e = 0; e < 300; e++) begin
            decoder_err = 0;
            for (int k = 0; k < 15; k++) tick();
            decoder_err = 1;
            tick();
        end
        decoder_err = 0;
        check("lerr_sat", {24'd0, link_err_cnt}, 32'd255);
        check("sat_still_run", {29'd0, state}, 32'd4);

        // RESET in RUN.
        RESET = 1;
        tick();
        check("reset_in_run", {9'd0, state, rx_reset, enable_rx, link_up, fail, retry_cnt, link_err_cnt}, 32'd0);
        RESET = 0;

        // Randomized run against the model.
        enable_req = 1; rec_sync_ready = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(99) < 2) rec_sync_ready = ~rec_sync_ready;
            enable_req  = ($urandom_range(199) != 0);
            decoder_err = ($urandom_range(15) == 0);
            err_reset   = ($urandom_range(63) == 0);
            RESET       = ($urandom_range(999) == 0);
            tick();
        end
        RESET = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
